// File: rtl/eeg_pea_eng_pe_mc_if.sv
// Input beat and output drain channels of the multi-channel PE.
// The PE is the slave side; producer and consumer sit behind the master modport.
interface eeg_pea_eng_pe_mc_if #(
  parameter int DATA_ACT_DW = 8,
  parameter int DATA_WEI_DW = 8,
  parameter int DATA_OUT_DW = 8,
  parameter int OCH_NUM     = 4,
  parameter int OMUX_ADD_AW = 8
);
  localparam int CHN_W = (OCH_NUM > 1) ? $clog2(OCH_NUM) : 1;

  logic                           DIN_VLD;
  logic                           DIN_RDY;
  logic                           WEI_LST;
  logic                           ACT_LST;
  logic [DATA_ACT_DW-1:0]         ACT_DAT;
  logic [OCH_NUM*DATA_WEI_DW-1:0] WEI_DAT;
  logic                           OUT_VLD;
  logic                           OUT_RDY;
  logic [DATA_OUT_DW-1:0]         OUT_DAT;
  logic [CHN_W-1:0]               OUT_CHN;
  logic [OMUX_ADD_AW-1:0]         OUT_ADD;
  logic                           OUT_LST;

  modport master (
    output DIN_VLD, WEI_LST, ACT_LST, ACT_DAT, WEI_DAT, OUT_RDY,
    input  DIN_RDY, OUT_VLD, OUT_DAT, OUT_CHN, OUT_ADD, OUT_LST
  );

  modport slave (
    input  DIN_VLD, WEI_LST, ACT_LST, ACT_DAT, WEI_DAT, OUT_RDY,
    output DIN_RDY, OUT_VLD, OUT_DAT, OUT_CHN, OUT_ADD, OUT_LST
  );
endinterface

// File: rtl/eeg_pea_eng_pe_mc.sv
// Multi-channel MAC PE: accumulates ACT*WEI per channel, drains one requantised channel per cycle.
// Point result valid the cycle after its WEI_LST beat; only a WEI_LST beat stalls, and only while the previous point drains.
module eeg_pea_eng_pe_mc #(
  parameter int DATA_ACT_DW = 8,
  parameter int DATA_WEI_DW = 8,
  parameter int DATA_OUT_DW = 8,
  parameter int DATA_SUM_DW = 24,
  parameter int OCH_NUM     = 4,
  parameter int CONV_MUL_DW = 16,
  parameter int CONV_SFT_DW = 4,
  parameter int CONV_ADD_DW = 24,
  parameter int OMUX_ADD_AW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   IS_IDLE,
  input  logic [CONV_MUL_DW-1:0] CFG_CONV_MUL,
  input  logic [CONV_SFT_DW-1:0] CFG_CONV_SFT,
  input  logic [CONV_ADD_DW-1:0] CFG_CONV_ADD,
  input  logic                   CFG_RELU,
  input  logic                   CFG_RND,
  eeg_pea_eng_pe_mc_if.slave     bus
);
  localparam int CHN_W = (OCH_NUM > 1) ? $clog2(OCH_NUM) : 1;
  localparam int PRD_W = DATA_ACT_DW + DATA_WEI_DW;
  localparam int RQ_W  = DATA_SUM_DW + CONV_MUL_DW + 1;
  localparam logic [CHN_W-1:0] LAST_CHN = CHN_W'(OCH_NUM - 1);
  localparam logic signed [RQ_W-1:0] OMAX = {{(RQ_W-DATA_OUT_DW+1){1'b0}}, {(DATA_OUT_DW-1){1'b1}}};
  localparam logic signed [RQ_W-1:0] OMIN = {{(RQ_W-DATA_OUT_DW+1){1'b1}}, {(DATA_OUT_DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                        state;
  logic signed [DATA_SUM_DW-1:0] acc  [OCH_NUM];
  logic signed [DATA_SUM_DW-1:0] dbuf [OCH_NUM];
  logic signed [DATA_SUM_DW-1:0] sum  [OCH_NUM];
  logic signed [PRD_W-1:0]       prd  [OCH_NUM];
  logic                          first_tap;
  logic                          dbuf_vld;
  logic                          pt_lst;
  logic [CHN_W-1:0]              chn;
  logic [OMUX_ADD_AW-1:0]        pt_add;
  logic [OMUX_ADD_AW-1:0]        pt_cnt;
  logic                          din_ena;
  logic                          out_ena;
  logic                          drain_done;
  logic                          last_chn;
  logic                          pt_end;
  logic                          run_end;
  logic signed [DATA_SUM_DW-1:0] sel;
  logic signed [RQ_W-1:0]        a_ext;
  logic signed [RQ_W-1:0]        m_ext;
  logic signed [RQ_W-1:0]        d_ext;
  logic signed [RQ_W-1:0]        v;
  logic [DATA_OUT_DW-1:0]        q;

  assign last_chn    = (chn == LAST_CHN);
  assign out_ena     = dbuf_vld & bus.OUT_RDY;
  assign drain_done  = out_ena & last_chn;
  // A point-closing beat may enter in the very cycle the last channel leaves.
  assign bus.DIN_RDY = ~dbuf_vld | ~bus.WEI_LST | drain_done;
  assign din_ena     = bus.DIN_VLD & bus.DIN_RDY;
  assign pt_end      = din_ena & bus.WEI_LST;
  assign run_end     = pt_end & bus.ACT_LST;

  always_comb begin
    for (int c = 0; c < OCH_NUM; c++) begin
      prd[c] = $signed(bus.ACT_DAT) * $signed(bus.WEI_DAT[c*DATA_WEI_DW +: DATA_WEI_DW]);
      sum[c] = (first_tap ? '0 : acc[c]) + {{(DATA_SUM_DW-PRD_W){prd[c][PRD_W-1]}}, prd[c]};
    end
  end

  always_comb begin
    sel   = dbuf[chn];
    a_ext = {{(RQ_W-DATA_SUM_DW){sel[DATA_SUM_DW-1]}}, sel};
    m_ext = {{(RQ_W-CONV_MUL_DW){CFG_CONV_MUL[CONV_MUL_DW-1]}}, CFG_CONV_MUL};
    d_ext = {{(RQ_W-CONV_ADD_DW){CFG_CONV_ADD[CONV_ADD_DW-1]}}, CFG_CONV_ADD};
    v     = a_ext * m_ext + d_ext;
    if (CFG_RND && (CFG_CONV_SFT != '0))
      v = v + ({{(RQ_W-1){1'b0}}, 1'b1} << (CFG_CONV_SFT - CONV_SFT_DW'(1)));
    v = v >>> CFG_CONV_SFT;
    if (CFG_RELU && v[RQ_W-1])
      q = '0;
    else if (v > OMAX)
      q = OMAX[DATA_OUT_DW-1:0];
    else if (v < OMIN)
      q = OMIN[DATA_OUT_DW-1:0];
    else
      q = v[DATA_OUT_DW-1:0];
  end

  assign bus.OUT_VLD = dbuf_vld;
  assign bus.OUT_DAT = dbuf_vld ? q : '0;
  assign bus.OUT_CHN = chn;
  assign bus.OUT_ADD = pt_add;
  assign bus.OUT_LST = dbuf_vld & pt_lst & last_chn;
  assign IS_IDLE     = (state == IDLE) & ~dbuf_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < OCH_NUM; c++) begin
        acc[c]  <= '0;
        dbuf[c] <= '0;
      end
      first_tap <= 1'b1;
      dbuf_vld  <= 1'b0;
      pt_lst    <= 1'b0;
      pt_add    <= '0;
      pt_cnt    <= '0;
      chn       <= '0;
    end else begin
      if (din_ena) begin
        for (int c = 0; c < OCH_NUM; c++) begin
          acc[c] <= bus.WEI_LST ? '0 : sum[c];
          if (bus.WEI_LST)
            dbuf[c] <= sum[c];
        end
        first_tap <= bus.WEI_LST;
      end
      if (pt_end) begin
        dbuf_vld <= 1'b1;
        pt_lst   <= bus.ACT_LST;
        pt_add   <= pt_cnt;
        pt_cnt   <= bus.ACT_LST ? '0 : pt_cnt + OMUX_ADD_AW'(1);
      end else if (drain_done) begin
        dbuf_vld <= 1'b0;
      end
      if (drain_done)
        chn <= '0;
      else if (out_ena)
        chn <= chn + CHN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (din_ena) state <= run_end ? FLUSH : RUN;
        RUN:     if (run_end) state <= FLUSH;
        FLUSH: begin
          if (din_ena)         state <= run_end ? FLUSH : RUN;
          else if (drain_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eeg_pea_eng_pe_mc.sv
// Bench for the multi-channel PE with OCH_NUM=2: directed cases plus randomized runs vs. an arithmetic model.
module tb_eeg_pea_eng_pe_mc;
  localparam int OCH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic is_idle;
  logic [15:0] cfg_mul;
  logic [3:0]  cfg_sft;
  logic [23:0] cfg_add;
  logic        cfg_relu;
  logic        cfg_rnd;

  always #5 clk = ~clk;

  eeg_pea_eng_pe_mc_if #(.OCH_NUM(OCH)) bus ();

  eeg_pea_eng_pe_mc #(.OCH_NUM(OCH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IS_IDLE      (is_idle),
    .CFG_CONV_MUL (cfg_mul),
    .CFG_CONV_SFT (cfg_sft),
    .CFG_CONV_ADD (cfg_add),
    .CFG_RELU     (cfg_relu),
    .CFG_RND      (cfg_rnd),
    .bus          (bus)
  );

  typedef struct {
    longint dat;
    int     chn;
    int     add;
    bit     lst;
  } exp_t;

  int     nvec = 0;
  int     nerr = 0;
  int     cyc  = 0;
  exp_t   exp_q[$];
  exp_t   mon_e;
  longint obs_dat[$];
  int     obs_add[$];
  int     obs_cyc[$];
  longint msum[OCH];
  int     mpt;
  int     cur_act;
  int     cur_w[OCH];
  bit     cur_wl;
  bit     cur_al;
  int     accept_cyc;
  bit     rdone;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint wrap24(longint s);
    longint r = s & 'hFF_FFFF;
    if (r >= 'h80_0000) r = r - 'h100_0000;
    return r;
  endfunction

  function automatic longint requant(longint a);
    longint v = a * longint'($signed(cfg_mul)) + longint'($signed(cfg_add));
    if (cfg_rnd && cfg_sft > 0) v = v + (longint'(1) << (cfg_sft - 1));
    v = v >>> cfg_sft;
    if (cfg_relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic model_beat();
    exp_t e;
    for (int c = 0; c < OCH; c++) msum[c] += longint'(cur_act) * longint'(cur_w[c]);
    if (cur_wl) begin
      for (int c = 0; c < OCH; c++) begin
        e.dat = requant(wrap24(msum[c]));
        e.chn = c;
        e.add = mpt;
        e.lst = cur_al && (c == OCH - 1);
        exp_q.push_back(e);
        msum[c] = 0;
      end
      mpt = cur_al ? 0 : (mpt + 1) % 256;
    end
  endtask

  task automatic present(int act, int w0, int w1, bit wl, bit al);
    cur_act = act;
    cur_w[0] = w0;
    cur_w[1] = w1;
    cur_wl = wl;
    cur_al = al;
    bus.ACT_DAT = 8'(act);
    bus.WEI_DAT = {8'(w1), 8'(w0)};
    bus.WEI_LST = wl;
    bus.ACT_LST = al;
    bus.DIN_VLD = 1'b1;
  endtask

  // Returns at posedge+1 with the beat either accepted (and modelled) or timed out.
  task automatic complete();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.DIN_RDY === 1'b1) begin
        ok = 1'b1;
        accept_cyc = cyc;
        break;
      end
    end
    if (!ok) chk("din_rdy_timeout", bus.DIN_RDY, 1);
    @(posedge clk);
    if (ok) model_beat();
    #1;
    bus.DIN_VLD = 1'b0;
  endtask

  task automatic send(int act, int w0, int w1, bit wl, bit al);
    present(act, w0, w1, wl, al);
    complete();
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (is_idle === 1'b1) break;
    end
    chk(tag, is_idle, 1);
    chk({tag, "_pending"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_outputs(string tag);
    chk({tag, "_vld"}, bus.OUT_VLD, 0);
    chk({tag, "_lst"}, bus.OUT_LST, 0);
    chk({tag, "_dat"}, $signed(bus.OUT_DAT), 0);
    chk({tag, "_chn"}, bus.OUT_CHN, 0);
    chk({tag, "_add"}, bus.OUT_ADD, 0);
    chk({tag, "_idle"}, is_idle, 1);
    chk({tag, "_rdy"}, bus.DIN_RDY, 1);
  endtask

  task automatic clear_obs();
    obs_dat.delete();
    obs_add.delete();
    obs_cyc.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.OUT_VLD === 1'b1 && bus.OUT_RDY === 1'b1) begin
      obs_dat.push_back(longint'($signed(bus.OUT_DAT)));
      obs_add.push_back(int'(bus.OUT_ADD));
      obs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("spurious_out", bus.OUT_VLD, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_dat", $signed(bus.OUT_DAT), mon_e.dat);
        chk("out_chn", bus.OUT_CHN, mon_e.chn);
        chk("out_add", bus.OUT_ADD, mon_e.add);
        chk("out_lst", bus.OUT_LST, mon_e.lst);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.DIN_VLD = 1'b0;
    bus.WEI_LST = 1'b0;
    bus.ACT_LST = 1'b0;
    bus.ACT_DAT = '0;
    bus.WEI_DAT = '0;
    bus.OUT_RDY = 1'b1;
    cfg_mul = 16'd1;
    cfg_sft = 4'd0;
    cfg_add = 24'd0;
    cfg_relu = 1'b0;
    cfg_rnd = 1'b0;
    for (int c = 0; c < OCH; c++) msum[c] = 0;
    mpt = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 3-tap point: ch0 = 6, ch1 = 3
    clear_obs();
    send(1, 1, -1, 0, 0);
    send(2, 1, 2, 0, 0);
    send(3, 1, 0, 1, 1);
    wait_idle("basic_idle");
    chk("basic_cnt", obs_dat.size(), 2);
    chk("basic_ch0", obs_dat[0], 6);
    chk("basic_ch1", obs_dat[1], 3);
    chk("basic_add", obs_add[0], 0);

    // Saturation and ReLU
    clear_obs();
    send(100, 2, -3, 1, 1);
    wait_idle("sat_idle");
    chk("sat_pos", obs_dat[0], 127);
    chk("sat_neg", obs_dat[1], -128);
    cfg_relu = 1'b1;
    send(5, -1, 1, 1, 1);
    wait_idle("relu_idle");
    chk("relu_neg", obs_dat[2], 0);
    chk("relu_pos", obs_dat[3], 5);
    cfg_relu = 1'b0;

    // Rounding and scale/offset
    clear_obs();
    cfg_sft = 4'd1;
    cfg_rnd = 1'b1;
    send(5, 1, 1, 1, 1);
    wait_idle("rnd1_idle");
    cfg_rnd = 1'b0;
    send(5, 1, 1, 1, 1);
    wait_idle("rnd0_idle");
    cfg_sft = 4'd0;
    cfg_mul = 16'd3;
    cfg_add = 24'hFF_FFFC;
    send(10, 1, 2, 1, 1);
    wait_idle("scale_idle");
    chk("rnd_on", obs_dat[0], 3);
    chk("rnd_off", obs_dat[2], 2);
    chk("scale_ch0", obs_dat[4], 26);
    chk("scale_ch1", obs_dat[5], 56);
    cfg_mul = 16'd1;
    cfg_add = 24'd0;

    // Backpressure on a point-closing beat
    clear_obs();
    bus.OUT_RDY = 1'b0;
    send(1, 3, 4, 0, 0);
    send(2, 5, 6, 1, 0);
    send(7, 1, 1, 0, 0);
    present(1, 2, 3, 1, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_din_rdy", bus.DIN_RDY, 0);
      chk("bp_vld", bus.OUT_VLD, 1);
      chk("bp_hold_dat", $signed(bus.OUT_DAT), 13);
      chk("bp_hold_chn", bus.OUT_CHN, 0);
    end
    @(posedge clk);
    #1;
    bus.OUT_RDY = 1'b1;
    complete();
    wait_idle("bp_idle");
    chk("bp_cnt", obs_dat.size(), 4);
    chk("bp_accept_cycle", accept_cyc, obs_cyc[1]);

    // Back-to-back single-tap points
    clear_obs();
    send(1, 1, 1, 1, 0);
    send(2, 1, 1, 1, 0);
    send(3, 1, 1, 1, 1);
    wait_idle("b2b_idle");
    chk("b2b_cnt", obs_dat.size(), 6);
    for (int i = 0; i < 6; i++) chk("b2b_add", obs_add[i], i / 2);
    for (int i = 1; i < 6; i++) chk("b2b_gap", obs_cyc[i] - obs_cyc[i-1], 1);

    // Reset in the middle of a drain
    bus.OUT_RDY = 1'b0;
    send(4, 1, 1, 1, 1);
    send(9, 9, 9, 0, 0);
    bus.OUT_RDY = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.OUT_RDY = 1'b0;
    exp_q.delete();
    for (int c = 0; c < OCH; c++) msum[c] = 0;
    mpt = 0;
    @(negedge clk);
    reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.OUT_RDY = 1'b1;
    clear_obs();
    send(2, 3, 4, 0, 0);
    send(1, 1, 1, 1, 0);
    send(5, 1, -1, 1, 1);
    wait_idle("rst_run_idle");
    chk("rst_run_add", obs_add[0], 0);
    chk("rst_run_ch0", obs_dat[0], 7);
    chk("rst_run_ch1", obs_dat[1], 9);

    // Randomized runs with random output backpressure
    for (int run = 0; run < 12; run++) begin
      cfg_mul  = (run % 2 == 1) ? 16'(int'($urandom_range(0, 7)) - 3) : 16'($urandom);
      cfg_sft  = 4'($urandom_range(0, 6));
      cfg_add  = 24'(int'($urandom_range(0, 200)) - 100);
      cfg_relu = 1'($urandom_range(0, 1));
      cfg_rnd  = 1'($urandom_range(0, 1));
      rdone = 1'b0;
      fork
        begin
          int npts = int'($urandom_range(1, 5));
          for (int p = 0; p < npts; p++) begin
            int ntaps = int'($urandom_range(1, 4));
            for (int t = 0; t < ntaps; t++)
              send(int'($urandom_range(0, 255)) - 128,
                   int'($urandom_range(0, 255)) - 128,
                   int'($urandom_range(0, 255)) - 128,
                   t == ntaps - 1, (t == ntaps - 1) && (p == npts - 1));
          end
          rdone = 1'b1;
        end
        begin
          while (!rdone) begin
            @(posedge clk);
            #1;
            bus.OUT_RDY = ($urandom_range(0, 3) != 0);
          end
        end
      join
      bus.OUT_RDY = 1'b1;
      wait_idle("rand_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
